// File: rtl/timer.sv
// Three-digit BCD M:SS countdown timer for the microwave controller.
// Digits shift in from the right; counting stops at 0:00 and never wraps.
module timer (
  input  logic       clock,
  input  logic       clearn,
  input  logic [3:0] data,
  input  logic       loadn,
  input  logic       en,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       zero
);

  logic [1:0] arm_q;
  logic       armed;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] mins_q, mins_d;
  logic       zero_w;

  // Clear releases through two flops so no load or count happens on the
  // edge that coincides with clearn rising.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      arm_q <= 2'b00;
    end else begin
      arm_q <= {arm_q[0], 1'b1};
    end
  end

  assign armed  = arm_q[1];
  assign zero_w = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    mins_d = mins_q;
    if (armed) begin
      if (!loadn) begin
        if (data <= 4'd9) begin
          mins_d = tens_q;
          tens_d = ones_q;
          ones_d = data;
        end
      end else if (en && !zero_w) begin
        if (ones_q != 4'd0) begin
          ones_d = ones_q - 4'd1;
        end else begin
          ones_d = 4'd9;
          if (tens_q != 4'd0) begin
            tens_d = tens_q - 4'd1;
          end else begin
            // Not at 0:00 with both seconds digits zero, so mins is nonzero.
            tens_d = 4'd5;
            mins_d = mins_q - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      mins_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      mins_q <= mins_d;
    end
  end

  assign sec_ones = ones_q;
  assign sec_tens = tens_q;
  assign mins     = mins_q;
  assign zero     = zero_w;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for the M:SS countdown timer: vector table plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_timer;

  logic       clock;
  logic       clearn;
  logic [3:0] data;
  logic       loadn;
  logic       en;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       zero;

  int tests;
  int fails;

  typedef struct {
    string      name;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       z;
  } exp_t;

  typedef struct {
    logic       loadn;
    logic       en;
    logic [3:0] data;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       z;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  timer dut (
    .clock    (clock),
    .clearn   (clearn),
    .data     (data),
    .loadn    (loadn),
    .en       (en),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .mins     (mins),
    .zero     (zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic compare(input string nm, input logic [3:0] em, input logic [3:0] et,
                         input logic [3:0] eo, input logic ez);
    tests++;
    if (mins !== em || sec_tens !== et || sec_ones !== eo || zero !== ez) begin
      fails++;
      $display("[TB] FAIL %s: got %0d:%0d%0d zero=%0b, want %0d:%0d%0d zero=%0b",
               nm, mins, sec_tens, sec_ones, zero, em, et, eo, ez);
    end else begin
      $display("[TB] ok   %s: %0d:%0d%0d zero=%0b", nm, mins, sec_tens, sec_ones, zero);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard: queue empty, got %0d:%0d%0d, want an entry",
               mins, sec_tens, sec_ones);
    end else begin
      tests--;
      e = sb_q.pop_front();
      compare(e.name, e.m, e.t, e.o, e.z);
    end
  endtask

  // Drive one edge; when chk is set the expectation is queued at drive time
  // and popped once the edge has produced its result.
  task automatic step(input logic ln, input logic e, input logic [3:0] d, input bit chk,
                      input string nm, input logic [3:0] em, input logic [3:0] et,
                      input logic [3:0] eo, input logic ez);
    exp_t x;
    loadn = ln;
    en    = e;
    data  = d;
    if (chk) begin
      x.name = nm; x.m = em; x.t = et; x.o = eo; x.z = ez;
      sb_q.push_back(x);
    end
    @(posedge clock);
    #1;
    if (chk) pop_compare();
  endtask

  task automatic run_count(input int n, input string nm, input logic [3:0] em,
                           input logic [3:0] et, input logic [3:0] eo, input logic ez);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, 4'd0, (i == n - 1), nm, em, et, eo, ez);
    end
  endtask

  task automatic load_digit(input logic [3:0] d);
    step(1'b0, 1'b0, d, 1'b0, "", 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    clearn = 1'b0;
    loadn  = 1'b1;
    en     = 1'b0;
    data   = 4'd0;

    vecs[0]  = '{1'b0, 1'b0, 4'd8,  4'd0, 4'd0, 4'd8, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'd5,  4'd0, 4'd8, 4'd5, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'd7,  4'd8, 4'd5, 4'd7, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'd3,  4'd5, 4'd7, 4'd3, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd12, 4'd5, 4'd7, 4'd3, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'd6,  4'd5, 4'd7, 4'd3, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'd0,  4'd5, 4'd7, 4'd2, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 4'd0,  4'd5, 4'd7, 4'd2, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 4'd0,  4'd5, 4'd7, 4'd1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'd9,  4'd7, 4'd1, 4'd9, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'd4,  4'd7, 4'd1, 4'd8, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'd15, 4'd7, 4'd1, 4'd8, 1'b0};

    // Reset held: loads and enables must not disturb the cleared state.
    #2;
    compare("reset_t0", 4'd0, 4'd0, 4'd0, 1'b1);
    step(1'b0, 1'b0, 4'd7, 1'b1, "reset_load_blocked", 4'd0, 4'd0, 4'd0, 1'b1);
    step(1'b0, 1'b1, 4'd2, 1'b1, "reset_load_blocked2", 4'd0, 4'd0, 4'd0, 1'b1);
    step(1'b1, 1'b1, 4'd5, 1'b1, "reset_count_blocked", 4'd0, 4'd0, 4'd0, 1'b1);

    clearn = 1'b1;
    step(1'b0, 1'b0, 4'd4, 1'b1, "release_edge_no_load", 4'd0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'd0, 1'b1, "post_release_hold", 4'd0, 4'd0, 4'd0, 1'b1);
    end

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].loadn, vecs[i].en, vecs[i].data, 1'b1, $sformatf("vec%0d", i),
           vecs[i].m, vecs[i].t, vecs[i].o, vecs[i].z);
    end

    // Full countdown from 8:57 (537 s).
    load_digit(4'd8);
    load_digit(4'd5);
    step(1'b0, 1'b0, 4'd7, 1'b1, "load_857", 4'd8, 4'd5, 4'd7, 1'b0);
    run_count(1,   "cnt_1",   4'd8, 4'd5, 4'd6, 1'b0);
    run_count(6,   "cnt_7",   4'd8, 4'd5, 4'd0, 1'b0);
    run_count(1,   "cnt_8",   4'd8, 4'd4, 4'd9, 1'b0);
    run_count(49,  "cnt_57",  4'd8, 4'd0, 4'd0, 1'b0);
    run_count(1,   "cnt_58",  4'd7, 4'd5, 4'd9, 1'b0);
    run_count(478, "cnt_536", 4'd0, 4'd0, 4'd1, 1'b0);
    run_count(1,   "cnt_537", 4'd0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run_count(1, "terminal_hold", 4'd0, 4'd0, 4'd0, 1'b1);
    end

    // Entered tens above 5, with a pause in the middle.
    load_digit(4'd0);
    load_digit(4'd7);
    step(1'b0, 1'b0, 4'd0, 1'b1, "load_070", 4'd0, 4'd7, 4'd0, 1'b0);
    run_count(1,  "t70_1",  4'd0, 4'd6, 4'd9, 1'b0);
    run_count(9,  "t70_10", 4'd0, 4'd6, 4'd0, 1'b0);
    run_count(1,  "t70_11", 4'd0, 4'd5, 4'd9, 1'b0);
    run_count(19, "t70_30", 4'd0, 4'd4, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 4'd0, 1'b1, "pause", 4'd0, 4'd4, 4'd0, 1'b0);
    end
    run_count(39, "t70_69", 4'd0, 4'd0, 4'd1, 1'b0);
    run_count(1,  "t70_70", 4'd0, 4'd0, 4'd0, 1'b1);

    // Asynchronous clear mid-count at 3:21.
    load_digit(4'd3);
    load_digit(4'd2);
    step(1'b0, 1'b0, 4'd2, 1'b1, "load_322", 4'd3, 4'd2, 4'd2, 1'b0);
    run_count(1, "cnt_321", 4'd3, 4'd2, 4'd1, 1'b0);
    loadn = 1'b1;
    en    = 1'b1;
    #2;
    clearn = 1'b0;
    #1;
    compare("async_clear", 4'd0, 4'd0, 4'd0, 1'b1);
    step(1'b1, 1'b1, 4'd0, 1'b1, "clear_held", 4'd0, 4'd0, 4'd0, 1'b1);
    clearn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'd0, 1'b1, "after_clear_no_count", 4'd0, 4'd0, 4'd0, 1'b1);
    end

    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
